// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared constants, UART FSM state type and helpers for the
//               digital clock serial-report path.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } uart_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

    // Byte idx of the frame "HH:MM:SS\r\n"; values are sent literally, no clamping.
    function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                              input logic [4:0] hh,
                                              input logic [5:0] mm,
                                              input logic [5:0] ss);
        logic [7:0] b;
        case (idx)
            4'd0:       b = ASCII_ZERO + 8'(hh / 5'd10);
            4'd1:       b = ASCII_ZERO + 8'(hh % 5'd10);
            4'd2, 4'd5: b = ASCII_COLON;
            4'd3:       b = ASCII_ZERO + 8'(mm / 6'd10);
            4'd4:       b = ASCII_ZERO + 8'(mm % 6'd10);
            4'd6:       b = ASCII_ZERO + 8'(ss / 6'd10);
            4'd7:       b = ASCII_ZERO + 8'(ss % 6'd10);
            4'd8:       b = ASCII_CR;
            default:    b = ASCII_LF;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_tx
// Description : 8N1 LSB-first serializer with baud counter. A byte is loaded
//               whenever i_start is high while o_ready is high.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_tx
    import clock_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    output logic       o_tx,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] c_baud_last = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t      r_state;
    uart_state_t      w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_data;
    logic             w_baud_last;
    logic             w_ready;
    logic             w_load;

    assign w_baud_last = (r_cnt == c_baud_last);
    // Ready in the final stop-bit cycle too, so the next byte follows with no gap.
    assign w_ready     = (r_state == IDLE) || (r_state == DONE) ||
                         ((r_state == STOP) && w_baud_last);
    assign w_load      = w_ready && i_start;
    assign o_ready     = w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE, DONE: w_next_state = i_start ? START : IDLE;
            START:      if (w_baud_last) w_next_state = DATA;
            DATA:       if (w_baud_last && (r_bit_idx == 3'd7)) w_next_state = STOP;
            STOP:       if (w_baud_last) w_next_state = i_start ? START : DONE;
            default:    w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_tx   = 1'b1;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (r_state)
            START: begin
                o_tx   = 1'b0;
                o_busy = 1'b1;
            end
            DATA: begin
                o_tx   = r_data[r_bit_idx];
                o_busy = 1'b1;
            end
            STOP:    o_busy = 1'b1;
            DONE:    o_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_data    <= '0;
        end else if (w_load) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_data    <= i_byte;
        end else if (r_state inside {START, DATA, STOP}) begin
            r_cnt <= w_baud_last ? '0 : r_cnt + CNT_W'(1);
            if ((r_state == DATA) && w_baud_last && (r_bit_idx != 3'd7))
                r_bit_idx <= r_bit_idx + 3'd1;
        end else begin
            r_cnt <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/time_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : time_uart_tx
// Description : Snapshots hh:mm:ss on send and transmits "HH:MM:SS\r\n" as
//               10 back-to-back 8N1 bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module time_uart_tx
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       send,
    input  logic [4:0] hours,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int         CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
    localparam logic [3:0] c_last_byte  = 4'd9;

    logic [4:0] r_hours;
    logic [5:0] r_minutes;
    logic [5:0] r_seconds;
    logic [3:0] r_byte_idx;
    logic       w_ready;
    logic       w_busy;
    logic       w_accept;
    logic       w_more;
    logic       w_start;
    logic [7:0] w_byte;

    assign w_accept = send && !w_busy;
    assign w_more   = w_busy && w_ready && (r_byte_idx != c_last_byte);
    assign w_start  = w_accept || w_more;
    // First byte comes straight from the live inputs; the snapshot lands on the same edge.
    assign w_byte   = w_accept ? frame_byte(4'd0, hours, minutes, seconds)
                               : frame_byte(r_byte_idx + 4'd1, r_hours, r_minutes, r_seconds);
    assign busy     = w_busy;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_hours    <= '0;
            r_minutes  <= '0;
            r_seconds  <= '0;
            r_byte_idx <= '0;
        end else if (w_accept) begin
            r_hours    <= hours;
            r_minutes  <= minutes;
            r_seconds  <= seconds;
            r_byte_idx <= '0;
        end else if (w_more) begin
            r_byte_idx <= r_byte_idx + 4'd1;
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte_tx (
        .clk     (CLOCK_50),
        .rst_n   (reset_n),
        .i_start (w_start),
        .i_byte  (w_byte),
        .o_tx    (tx),
        .o_ready (w_ready),
        .o_busy  (w_busy),
        .o_done  (done)
    );

endmodule
`default_nettype wire

// File: tb/tb_time_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_uart_tx
// Description : Directed self-checking bench for time_uart_tx at 10 clocks/bit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_uart_tx;

    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic       send;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       tx;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] f1 [10];
    logic [7:0] f2 [10];
    logic [7:0] f3 [10];

    time_uart_tx #(
        .CLK_HZ (1000),
        .BAUD   (100)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .send     (send),
        .hours    (hours),
        .minutes  (minutes),
        .seconds  (seconds),
        .tx       (tx),
        .busy     (busy),
        .done     (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_pulse();
        send = 1'b1;
        @(negedge CLOCK_50);
        send = 1'b0;
    endtask

    task automatic check_idle(input string name, input int n);
        int err;
        err = 0;
        for (int i = 0; i < n; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) err++;
            @(negedge CLOCK_50);
        end
        check({name, "_idle"}, err, 0);
    endtask

    // Starts on the first start-bit cycle, ends on the done cycle (not stepped past).
    task automatic run_frame(input string name, input logic [7:0] exp [10], input int mode);
        int         err_tx, err_busy, err_done, b, k;
        logic       exp_bit;
        logic [7:0] rx [10];
        err_tx = 0; err_busy = 0; err_done = 0;
        for (int i = 0; i < 10; i++) rx[i] = 8'h00;
        for (int c = 0; c < 1000; c++) begin
            b = c / 100;
            k = (c % 100) / 10;
            if (k == 0)      exp_bit = 1'b0;
            else if (k == 9) exp_bit = 1'b1;
            else             exp_bit = exp[b][k-1];
            if (tx !== exp_bit) err_tx++;
            if (busy !== 1'b1)  err_busy++;
            if (done !== 1'b0)  err_done++;
            if ((c % 10 == 5) && k >= 1 && k <= 8) rx[b][k-1] = tx;
            if (mode == 1 && c == 300) begin
                hours = 5'd23; minutes = 6'd59; seconds = 6'd59;
            end
            if (mode == 2) send = (c == 100 || c == 550 || c == 998);
            @(negedge CLOCK_50);
        end
        check({name, "_tx_bits"}, err_tx, 0);
        check({name, "_busy_hi"}, err_busy, 0);
        check({name, "_done_lo"}, err_done, 0);
        for (int i = 0; i < 10; i++)
            check($sformatf("%s_byte%0d", name, i), rx[i], exp[i]);
        check({name, "_done_pulse"}, done, 1);
        check({name, "_busy_end"}, busy, 0);
        check({name, "_tx_end"}, tx, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        f1 = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
        f2 = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h37, 8'h0D, 8'h0A};
        f3 = '{8'h33, 8'h31, 8'h3A, 8'h30, 8'h35, 8'h3A, 8'h34, 8'h30, 8'h0D, 8'h0A};
        reset_n = 1'b0;
        send    = 1'b0;
        hours   = 5'd0;
        minutes = 6'd0;
        seconds = 6'd0;
        repeat (3) @(negedge CLOCK_50);
        reset_n = 1'b1;

        check_idle("reset", 50);

        hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
        send_pulse();
        run_frame("basic", f1, 0);
        @(negedge CLOCK_50);
        check_idle("after_basic", 20);

        // Inputs change mid-frame; a new send lands exactly in the done cycle.
        hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
        send_pulse();
        run_frame("snapshot", f1, 1);
        hours = 5'd0; minutes = 6'd0; seconds = 6'd7;
        send_pulse();
        run_frame("chained", f2, 0);
        @(negedge CLOCK_50);
        check_idle("after_chain", 20);

        hours = 5'd12; minutes = 6'd34; seconds = 6'd56;
        send_pulse();
        run_frame("ignore_busy", f1, 2);
        @(negedge CLOCK_50);
        check_idle("no_queue", 150);

        send_pulse();
        repeat (350) @(negedge CLOCK_50);
        check("busy_before_rst", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_tx", tx, 1);
        check("rst_async_busy", busy, 0);
        check("rst_async_done", done, 0);
        repeat (2) @(negedge CLOCK_50);
        reset_n = 1'b1;
        check_idle("after_rst", 20);

        hours = 5'd31; minutes = 6'd5; seconds = 6'd40;
        send_pulse();
        run_frame("post_rst", f3, 0);
        @(negedge CLOCK_50);
        check("final_done_lo", done, 0);
        check("final_busy_lo", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
